// File: rtl/load_store_unit.sv
// Memory-access stage: byte/half/word loads and stores on a byte-enabled word RAM,
// with a request/done handshake so the controller can stall while an access is in flight.
module load_store_unit #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        memReq,
  input  logic        DataMemRW,
  input  logic [1:0]  size,
  input  logic        signExt,
  input  logic [31:0] result,
  input  logic [31:0] readData2,
  input  logic        ALUM2Reg,
  output logic        ready,
  output logic        done,
  output logic        fault,
  output logic [31:0] write_data
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_WAIT = 3'd1,
    S_LD_DONE = 3'd2,
    S_ST_DONE = 3'd3,
    S_FAULT   = 3'd4
  } state_t;

  state_t            state_q;
  logic              ready_q;
  logic              done_q;
  logic              fault_q;
  logic [ADDR_W+1:0] addr_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic [31:0]       ram_q;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic              misaligned;
  logic              st_we;
  logic [3:0]        be;
  logic [31:0]       wdata;
  logic [ADDR_W-1:0] wr_idx;
  logic [31:0]       lane_word;
  logic [15:0]       half_sel;
  logic [31:0]       load_data;

  assign accept     = memReq && ready_q;
  assign misaligned = ((size == 2'b01) && result[0]) || (size[1] && (result[1:0] != 2'b00));
  assign st_we      = accept && DataMemRW && !misaligned;
  assign wr_idx     = result[ADDR_W+1:2];

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be    = 4'b0000;
    wdata = readData2;
    case (size)
      2'b00: begin
        be    = 4'b0001 << result[1:0];
        wdata = {4{readData2[7:0]}};
      end
      2'b01: begin
        be    = result[1] ? 4'b1100 : 4'b0011;
        wdata = {2{readData2[15:0]}};
      end
      default: begin
        be    = 4'b1111;
        wdata = readData2;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (st_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[wr_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      addr_q  <= '0;
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      ram_q   <= 32'h0;
    end else begin
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (misaligned) begin
              state_q <= S_FAULT;
              done_q  <= 1'b1;
              fault_q <= 1'b1;
            end else if (DataMemRW) begin
              state_q <= S_ST_DONE;
              done_q  <= 1'b1;
            end else begin
              // Latch everything the read and extraction need; result may move on.
              state_q <= S_LD_WAIT;
              addr_q  <= result[ADDR_W+1:0];
              size_q  <= size;
              sext_q  <= signExt;
            end
          end
        end
        S_LD_WAIT: begin
          ram_q   <= mem[addr_q[ADDR_W+1:2]];
          state_q <= S_LD_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign lane_word = ram_q >> {addr_q[1:0], 3'b000};
  assign half_sel  = addr_q[1] ? ram_q[31:16] : ram_q[15:0];

  always_comb begin
    case (size_q)
      2'b00:   load_data = {{24{sext_q & lane_word[7]}}, lane_word[7:0]};
      2'b01:   load_data = {{16{sext_q & half_sel[15]}}, half_sel};
      default: load_data = ram_q;
    endcase
  end

  assign write_data = ALUM2Reg ? load_data : result;
  assign ready      = ready_q;
  assign done       = done_q;
  assign fault      = fault_q;

endmodule
